// File: rtl/image_mode_ctrl.sv
// Display-mode selector: debounces next/prev keys, steps a pending mode with wrap-around,
// and commits it to the stream mux only on a camera frame boundary.
module image_mode_ctrl #(
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter int unsigned MODE_NUM     = 8,
   parameter bit          VS_POL       = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_next_n,
   input  logic       key_prev_n,
   input  logic       frame_vsync,
   output logic [3:0] mode,
   output logic       mode_pend,
   output logic       mode_chg
);

   localparam int unsigned CNT_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam int unsigned MODE_W = 4;
   localparam int unsigned NKEY   = 2;
   localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(MODE_NUM - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} db_state_e;

   // bit 0 = next key, bit 1 = prev key
   logic [NKEY-1:0]   key_s1_q, key_s2_q;
   logic              vs_s1_q, vs_s2_q, vs_prev_q;
   logic [NKEY-1:0]   press_c;
   logic              frame_edge_c;
   logic [MODE_W-1:0] mode_q, mode_d, pend_q, pend_d;
   logic              chg_q, chg_d, mpend_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q  <= '1;
         key_s2_q  <= '1;
         vs_s1_q   <= 1'b0;
         vs_s2_q   <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         key_s1_q  <= {key_prev_n, key_next_n};
         key_s2_q  <= key_s1_q;
         vs_s1_q   <= frame_vsync;
         vs_s2_q   <= vs_s1_q;
         vs_prev_q <= vs_s2_q;
      end
   end

   for (genvar k = 0; k < NKEY; k++) begin : g_db
      db_state_e        st_q, st_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             lvl;

      assign lvl = key_s2_q[k];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q  <= RELEASED;
            cnt_q <= '0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
         end
      end

      always_comb begin
         st_d  = st_q;
         cnt_d = cnt_q;
         case (st_q)
            RELEASED: begin
               if (!lvl) begin
                  st_d  = PRESS_CHK;
                  cnt_d = '0;
               end
            end
            PRESS_CHK: begin
               if (lvl)                    st_d  = RELEASED;
               else if (cnt_q == CNT_LAST) st_d  = PRESSED;
               else                        cnt_d = cnt_q + CNT_W'(1);
            end
            PRESSED: begin
               if (lvl) begin
                  st_d  = RELEASE_CHK;
                  cnt_d = '0;
               end
            end
            RELEASE_CHK: begin
               if (!lvl)                   st_d  = PRESSED;
               else if (cnt_q == CNT_LAST) st_d  = RELEASED;
               else                        cnt_d = cnt_q + CNT_W'(1);
            end
            default: st_d = RELEASED;
         endcase
      end

      // one press event on the cycle the press is accepted
      always_comb begin
         press_c[k] = 1'b0;
         if (st_q == PRESS_CHK && !lvl && cnt_q == CNT_LAST) press_c[k] = 1'b1;
      end
   end

   assign frame_edge_c = VS_POL ? (vs_s2_q & ~vs_prev_q) : (~vs_s2_q & vs_prev_q);

   // commit sees the pending value before this cycle's key step
   always_comb begin
      mode_d = mode_q;
      pend_d = pend_q;
      chg_d  = 1'b0;
      if (frame_edge_c && (pend_q != mode_q)) begin
         mode_d = pend_q;
         chg_d  = 1'b1;
      end
      if (press_c[0] && !press_c[1])
         pend_d = (pend_q == MODE_MAX) ? '0 : pend_q + MODE_W'(1);
      else if (press_c[1] && !press_c[0])
         pend_d = (pend_q == '0) ? MODE_MAX : pend_q - MODE_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= '0;
         pend_q  <= '0;
         chg_q   <= 1'b0;
         mpend_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         chg_q   <= chg_d;
         mpend_q <= (pend_d != mode_d);
      end
   end

   assign mode      = mode_q;
   assign mode_pend = mpend_q;
   assign mode_chg  = chg_q;

endmodule

// File: tb/tb_image_mode_ctrl.sv
// Scoreboard bench for image_mode_ctrl: stimulus pushes expected committed modes,
// a negedge monitor pops one per observed mode change.
module tb_image_mode_ctrl;

   localparam int N  = 16;
   localparam int MN = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_next_n, key_prev_n, frame_vsync;
   logic [3:0] mode;
   logic       mode_pend, mode_chg;

   int checks = 0;
   int fails  = 0;
   int m_mode = 0;
   int m_pend = 0;
   int exp_q[$];
   int prev_mode = 0;

   image_mode_ctrl #(.DEBOUNCE_CNT(N), .MODE_NUM(MN), .VS_POL(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .key_next_n(key_next_n), .key_prev_n(key_prev_n),
      .frame_vsync(frame_vsync), .mode(mode), .mode_pend(mode_pend), .mode_chg(mode_chg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string name);
      chk({name, "_mode"}, int'(mode), m_mode);
      chk({name, "_pend"}, int'(mode_pend), int'(m_pend != m_mode));
   endtask

   // press one or both keys for hold cycles; only long holds are accepted presses
   task automatic press(input bit nx, input bit pv, input int hold);
      key_next_n = ~nx;
      key_prev_n = ~pv;
      tick(hold);
      key_next_n = 1'b1;
      key_prev_n = 1'b1;
      tick(N + 8);
      if (hold >= N + 4) begin
         if (nx && !pv)      m_pend = (m_pend + 1) % MN;
         else if (pv && !nx) m_pend = (m_pend + MN - 1) % MN;
      end
   endtask

   task automatic frame_commit();
      if (m_pend != m_mode) begin
         exp_q.push_back(m_pend);
         m_mode = m_pend;
      end
   endtask

   task automatic vsync_pulse();
      frame_commit();
      frame_vsync = 1'b1;
      tick(8);
      frame_vsync = 1'b0;
      tick(8);
   endtask

   // every observed mode change must be a one-cycle chg pulse matching the scoreboard
   always @(negedge clk) begin
      if (!rst_n) prev_mode = 0;
      else begin
         if (mode_chg || int'(mode) != prev_mode) begin
            chk("chg_pulse", int'(mode_chg), 1);
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_chg: mode went to %0d, no commit expected", mode);
            end else begin
               chk("commit_mode", int'(mode), exp_q.pop_front());
            end
         end
         prev_mode = int'(mode);
      end
   end

   initial begin
      rst_n = 1'b0;
      key_next_n = 1'b1;
      key_prev_n = 1'b1;
      frame_vsync = 1'b0;
      tick(3);
      chk("rst_mode", int'(mode), 0);
      chk("rst_pend", int'(mode_pend), 0);
      chk("rst_chg", int'(mode_chg), 0);
      rst_n = 1'b1;
      tick(3);

      // 1: long next press, pending flag, then commit
      press(1'b1, 1'b0, 100);
      check_state("t1_press");
      vsync_pulse();
      check_state("t1_commit");

      // 2: bouncing press yields one step, then walk round to 0
      key_next_n = 1'b0; tick(5);
      key_next_n = 1'b1; tick(3);
      press(1'b1, 1'b0, 40);
      check_state("t2_bounce");
      vsync_pulse();
      for (int i = 0; i < 6; i++) begin
         press(1'b1, 1'b0, N + 6);
         vsync_pulse();
      end
      check_state("t2_wrap");

      // 3: prev wraps 0 -> 7, next wraps 7 -> 0
      press(1'b0, 1'b1, N + 10);
      vsync_pulse();
      check_state("t3_prev_wrap");
      press(1'b1, 1'b0, N + 10);
      vsync_pulse();
      check_state("t3_next_wrap");

      // 4: three nexts between frames commit once
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0, N + 5);
      vsync_pulse();
      check_state("t4_multi");

      // 5: simultaneous events cancel; step away and back clears pending
      press(1'b1, 1'b1, N + 10);
      check_state("t5_both");
      press(1'b1, 1'b0, N + 10);
      press(1'b0, 1'b1, N + 10);
      check_state("t5_back");
      vsync_pulse();
      check_state("t5_nochg");

      // 6a: press event in the same cycle as the frame edge
      press(1'b1, 1'b0, N + 10);
      key_next_n = 1'b0;
      tick(N);
      frame_commit();
      frame_vsync = 1'b1;
      m_pend = (m_pend + 1) % MN;
      tick(8);
      frame_vsync = 1'b0;
      tick(20);
      key_next_n = 1'b1;
      tick(N + 8);
      check_state("t6_coincide");
      vsync_pulse();
      check_state("t6_deferred");

      // 6b: reset in the middle of a press check
      key_next_n = 1'b0;
      tick(8);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_mode", int'(mode), 0);
      key_next_n = 1'b1;
      tick(3);
      m_mode = 0;
      m_pend = 0;
      exp_q.delete();
      rst_n = 1'b1;
      tick(N + 10);
      check_state("t6_post_rst");
      vsync_pulse();
      check_state("t6_post_rst_vs");

      // random mix of presses, rejected bounces and frames
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: press(1'b1, 1'b0, $urandom_range(N + 4, N + 40));
            1: press(1'b0, 1'b1, $urandom_range(N + 4, N + 40));
            2: press(1'b1, 1'b1, $urandom_range(N + 4, N + 20));
            3: press($urandom_range(0, 1) == 1, 1'b0, $urandom_range(1, N - 2));
            default: vsync_pulse();
         endcase
         check_state("rnd");
      end
      vsync_pulse();
      check_state("final");
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
